// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready output stream.
interface fifo_rd_stream_if #(parameter int WIDTH = 8);
    logic             rinc;
    logic             rempty;
    logic [WIDTH-1:0] rdata_in;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    modport master (output rinc, m_valid, m_data, input rempty, rdata_in, m_ready);
    modport slave  (input rinc, m_valid, m_data, output rempty, rdata_in, m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO read port into a buffered valid/ready stream.
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                i_ren,
    fifo_rd_stream_if.master    bus,
    output logic                o_busy,
    output logic [CNT_W-1:0]    o_rd_count
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t           r_state, w_next;
    logic [OW-1:0]    r_occ;
    logic             r_inflight;
    logic [PW-1:0]    r_head, r_tail;
    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic             w_push, w_pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_ren ? RUN : IDLE;
            RUN:     w_next = i_ren ? RUN : DRAIN;
            DRAIN:   w_next = i_ren ? RUN : (!r_inflight && r_occ == '0) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
    // Credit counts the word still in the RAM pipeline so the buffer can never overflow.
    assign bus.rinc    = (r_state == RUN) && !bus.rempty && (int'(r_occ) + int'(r_inflight) < BUF_DEPTH);
    assign w_push      = r_inflight;
    assign w_pop       = bus.m_valid && bus.m_ready;
    assign bus.m_valid = (r_occ != '0);
    assign bus.m_data  = bus.m_valid ? r_mem[r_head] : '0;
    assign o_busy      = (r_state != IDLE);
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state    <= IDLE;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            o_rd_count <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= bus.rinc;
            r_occ      <= r_occ + OW'(w_push) - OW'(w_pop);
            if (w_push) r_tail <= nxt(r_tail);
            if (w_pop) begin
                r_head     <= nxt(r_head);
                o_rd_count <= o_rd_count + 1'b1;
            end
        end
    end
    always_ff @(posedge rclk) begin
        if (w_push) r_mem[r_tail] <= bus.rdata_in;
    end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's FIFO read port (rinc / rempty / 1-cycle-latency rdata).
- Issues FIFO reads, absorbs the RAM read latency and re-times the words onto a valid/ready stream with a small internal buffer.
- Sustains one word per cycle when the downstream sink is always ready.
- Sits in the read clock domain, between the FIFO and the downstream consumer logic.

Parameters:
WIDTH, 8, data word width; must match the FIFO WIDTH.
BUF_DEPTH, 4, internal output-buffer entries; legal range 3..16; values below 3 lose full throughput.
CNT_W, 16, width of the drained-word counter.

Ports:
rclk  input  1  read-domain clock; all logic on posedge.
rrst  input  1  synchronous reset, active-high.
ren  input  1  drain enable.
rempty  input  1  FIFO empty flag, sampled in the same cycle as rinc.
rinc  output  1  FIFO read request.
rdata_in  input  WIDTH  FIFO read data, valid the cycle after an accepted read.
m_valid  output  1  output stream valid.
m_ready  input  1  output stream ready.
m_data  output  WIDTH  output stream data.
busy  output  1  FSM not in IDLE.
rd_count  output  CNT_W  words delivered on the stream, wrapping.

Behaviour:
- Reset (rrst=1 at a rclk edge):
  - rinc=0, m_valid=0, m_data=0, busy=0, rd_count=0.
  - Buffer occupancy and in-flight flag cleared; FSM goes to IDLE.
  - Any read in flight is discarded, even mid-operation; the word it fetched is lost by design.
- Accepted read: a cycle with rinc=1 and rempty=0.
  - rinc is combinational: rinc = (state==RUN) & ~rempty & (occ + inflight < BUF_DEPTH).
  - occ and inflight are registered values; a same-cycle pop is not credited.
  - rinc is never asserted while rempty=1.
- Latency:
  - The accepted read is in cycle T.
  - rdata_in is valid in T+1 and is written to the buffer tail at the end of T+1.
  - The word is visible on m_data with m_valid=1 in T+2 at the earliest.
- inflight register: set by an accepted read and cleared one cycle later. With inflight=1 a new read may still issue; the pipeline is one stage deep, so at most one word lands per cycle.
- Buffer:
  - FIFO order.
  - m_valid = (occ != 0).
  - m_data = head entry, zero when empty.
  - Pop happens on m_valid & m_ready.
  - Push and pop in the same cycle: occ unchanged, order preserved.
  - Pointers wrap modulo BUF_DEPTH.
  - Overflow is impossible given the rinc rule; the bench asserts occ <= BUF_DEPTH.
- Stream rule: once m_valid=1, m_data is held stable until the handshake completes.
- rd_count increments by 1 on each handshake and wraps from 2^CNT_W-1 to 0.
- FSM:
  - IDLE: goes to RUN when ren=1.
  - RUN: issues reads per the rinc rule. Goes to DRAIN when ren=0.
  - DRAIN:
    - No new reads; waits for inflight=0 and occ=0, still delivering buffered words.
    - Goes to IDLE when both are zero; if ren=1 again first, returns to RUN.
    - DRAIN to RUN takes priority over DRAIN to IDLE when ren=1 in the same cycle.
- busy = (state != IDLE).
- ren toggling in RUN takes effect on the next edge. A read issued in the same cycle that ren falls still completes and is delivered.
- rempty glitch-free assumption: none. rinc is gated each cycle by the current rempty value only.

Test Plan:
1. Reset then stream: FIFO preloaded with 0x11..0x18 (8 words), ren=1, m_ready=1 -> first m_valid exactly 3 cycles after ren rises (RUN entry plus 2-cycle latency); 8 consecutive beats 0x11..0x18, no bubbles; rd_count=8; rempty then holds rinc=0.
2. Backpressure: 8 words queued, m_ready=0 for 10 cycles -> rinc issues exactly BUF_DEPTH=4 reads then stops; m_data holds 0x11 stable. Release m_ready -> 0x11..0x18 delivered in order, no loss or duplication.
3. Alternating m_ready (1,0,1,0...) with a 20-word FIFO -> all 20 words delivered in order; rinc never asserted with rempty=1; occ never exceeds 4.
4. Disable mid-stream: drop ren in the same cycle as an accepted read -> that word is still delivered; busy stays 1 until the buffer empties, then goes 0; no further rinc.
5. Reset mid-operation: rrst=1 with occ=2 and inflight=1 -> next cycle m_valid=0, rinc=0, rd_count=0, busy=0; after ren=1, delivery resumes with the next FIFO word.
6. Counter wrap with CNT_W=4: 17 handshakes -> rd_count reads 15 after 15 handshakes, 0 after 16, 1 after 17.
